fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width per requester.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (1..255).
REQ-004 The block SHALL derive localparam ID_WIDTH = clog2(NUM_REQ), with a minimum of 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester data-valid.
REQ-008 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
REQ-010 The block SHALL have port fifo_wr_en, output, 1 bit: write strobe to the shared synchronous FIFO.
REQ-011 The block SHALL have port fifo_wr_data, output, ID_WIDTH+DATA_WIDTH bits: {grant_id, payload}.
REQ-012 The block SHALL have port fifo_wr_full, input, 1 bit: FIFO full flag, combinational from the FIFO.
REQ-013 The block SHALL have port grant_id, output, ID_WIDTH bits: the index of the current grant holder.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in state GRANT.

Function
REQ-015 The block SHALL implement FSM states IDLE and GRANT, with a registered state, grant_id, burst_cnt and rr_ptr.
REQ-016 In IDLE, if any req_valid is high, the block SHALL latch as grant_id the first valid index searching circularly from rr_ptr, clear burst_cnt and enter GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 In IDLE, req_ready SHALL be all zero and fifo_wr_en SHALL be 0.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal !fifo_wr_full and all other req_ready bits SHALL be 0; this path is combinational.
REQ-019 A beat is req_valid[grant_id] && req_ready[grant_id]; in the beat cycle, fifo_wr_en SHALL be 1 and fifo_wr_data SHALL be {grant_id, req_data slice}, with zero added latency.
REQ-020 Outside a beat, fifo_wr_en SHALL be 0 and fifo_wr_data SHALL hold its previous value.
REQ-021 Each beat SHALL increment burst_cnt; burst_cnt SHALL never exceed MAX_BURST.
REQ-022 The grant SHALL end on the edge where either a beat occurs with burst_cnt == MAX_BURST-1, or req_valid[grant_id] is low.
REQ-023 On grant end, the block SHALL set rr_ptr to (grant_id+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0, and return to IDLE.
REQ-024 Arbitration SHALL therefore cost one bubble cycle between grants.
REQ-025 While fifo_wr_full is high in GRANT, the block SHALL hold the grant indefinitely with burst_cnt frozen; no timeout applies.
REQ-026 If the granted valid drops while full is high, REQ-022 SHALL apply and the grant SHALL end.
REQ-027 Latency SHALL be: valid rising while in IDLE at edge n produces grant at edge n+1, with the first beat possible in that same cycle.
REQ-028 No requester SHALL wait more than (NUM_REQ-1) grants; round-robin fairness is mandatory.

Reset
REQ-029 While rst is high, the block SHALL asynchronously force: state=IDLE, grant_id=0, rr_ptr=0, burst_cnt=0, fifo_wr_data=0, fifo_wr_en=0, req_ready=0, busy=0.
REQ-030 Reset asserted mid-burst SHALL discard the grant; no write SHALL occur in any cycle with rst high.
REQ-031 After deassertion, the block SHALL arbitrate from rr_ptr=0 on the first clock edge.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=0, GRANT=1) and a clog2-style width function.
REQ-033 The block SHALL contain one sub-module, rr_pick: a combinational circular first-one finder with inputs {req_valid, rr_ptr} and outputs {found, index}.
REQ-034 The FIFO itself SHALL be instantiated outside this block.

Verification
REQ-035 Scenario: only req 2 valid with 10 beats, MAX_BURST=4, never full -> grants 2,2,2 with bursts 4,4,2, one bubble between grants, and fifo_wr_data[9:8]=2 on every write.
REQ-036 Scenario: all 4 valid continuously, MAX_BURST=1 -> grant order 0,1,2,3,0 with one write every 2 cycles.
REQ-037 Scenario: req 1 granted, fifo_wr_full forced high for 5 cycles after the 2nd beat -> req_ready[1]=0 for 5 cycles, burst_cnt stays at 2, then beats 3 and 4 and the grant ends.
REQ-038 Scenario: req 3 granted, valid drops after 1 beat -> grant ends, rr_ptr=0, and req 0 is chosen next if valid.
REQ-039 Scenario: rst pulsed during beat 2 of a burst by req 0 -> fifo_wr_en=0 during reset, all outputs at reset values, and the next grant picks the lowest valid index.
REQ-040 The bench SHALL include a scoreboard checking per-requester write order and the no-write-while-full rule for every cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared FSM encoding and width helper for the FIFO write arbiter
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Wide enough for any legal MAX_BURST (1..255).
    localparam int CNT_WIDTH = 8;

    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational circular first-one finder starting at rr_ptr
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] index
);

    logic [2*NUM_REQ-1:0] rotated;
    int                   slot;

    // Scan from the farthest offset back to the nearest so the nearest valid wins.
    always_comb begin
        found   = 1'b0;
        index   = '0;
        slot    = 0;
        rotated = {req_valid, req_valid} >> rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                slot = int'(rr_ptr) + i;
                if (slot >= NUM_REQ) begin
                    slot = slot - NUM_REQ;
                end
                found = 1'b1;
                index = ID_WIDTH'(slot);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding a shared FIFO write port
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int ID_WIDTH   = clog2_min1(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                           fifo_wr_full,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy
);

    arb_state_e                     state_q, state_d;
    logic [ID_WIDTH-1:0]            grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]           burst_cnt_q, burst_cnt_d;
    logic [ID_WIDTH+DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                           pick_found;
    logic [ID_WIDTH-1:0]            pick_index;
    logic                           beat;
    logic [DATA_WIDTH-1:0]          req_payload [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_payload
        assign req_payload[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (pick_found),
        .index     (pick_index)
    );

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wr_data_d   = wr_data_q;
        req_ready   = '0;
        fifo_wr_en  = 1'b0;
        beat        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d  = pick_index;
                    burst_cnt_d = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                req_ready[grant_id_q] = !fifo_wr_full;
                beat = req_valid[grant_id_q] && !fifo_wr_full;
                if (beat) begin
                    fifo_wr_en  = 1'b1;
                    wr_data_d   = {grant_id_q, req_payload[grant_id_q]};
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // A full FIFO with the requester still valid simply holds the grant.
                if (!req_valid[grant_id_q] ||
                    (beat && burst_cnt_q == CNT_WIDTH'(MAX_BURST - 1))) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // wr_data_d already equals wr_data_q outside a beat, giving hold behaviour for free.
    assign fifo_wr_data = wr_data_d;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [9:0]  fifo_wr_data;
    logic        fifo_wr_full;
    logic [1:0]  grant_id;
    logic        busy;

    logic [3:0]  b_req_valid;
    logic [31:0] b_req_data;
    logic [3:0]  b_req_ready;
    logic        b_wr_en;
    logic [9:0]  b_wr_data;
    logic        b_wr_full;
    logic [1:0]  b_grant_id;
    logic        b_busy;

    int          checks;
    int          errors;
    int          rem [4];
    logic [7:0]  pay [4];
    logic [7:0]  exp_pay [4];
    int          wr_log [$];
    int          cyc;
    logic [31:0] en_hist;
    logic [31:0] busy_hist;
    logic [9:0]  last_data;
    logic        s_en;
    logic [9:0]  s_data;
    logic [3:0]  s_ready;
    logic        s_busy;
    logic [1:0]  s_gid;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_full (fifo_wr_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (b_req_valid),
        .req_data     (b_req_data),
        .req_ready    (b_req_ready),
        .fifo_wr_en   (b_wr_en),
        .fifo_wr_data (b_wr_data),
        .fifo_wr_full (b_wr_full),
        .grant_id     (b_grant_id),
        .busy         (b_busy)
    );

    always #5 clk = ~clk;

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (rem[i] > 0);
            req_data[i*8 +: 8] = pay[i];
        end
    endtask

    task automatic set_req(input int idx, input int n, input logic [7:0] base);
        rem[idx]     = n;
        pay[idx]     = base;
        exp_pay[idx] = base;
    endtask

    task automatic clear_tracking();
        cyc       = 0;
        en_hist   = '0;
        busy_hist = '0;
        last_data = '0;
        wr_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        apply();
        fifo_wr_full = 1'b0;
        b_req_valid  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_tracking();
    endtask

    // One clock of the main DUT: scoreboard at negedge, requester model update after posedge.
    task automatic cycle();
        logic [1:0] wid;
        wid = '0;
        @(negedge clk);
        s_en    = fifo_wr_en;
        s_data  = fifo_wr_data;
        s_ready = req_ready;
        s_busy  = busy;
        s_gid   = grant_id;
        checks++;
        if (s_en && fifo_wr_full) begin
            errors++;
            $display("FAIL wr_while_full cyc=%0d wr_en=%b full=%b", cyc, s_en, fifo_wr_full);
        end
        checks++;
        if (s_en !== |(req_valid & s_ready)) begin
            errors++;
            $display("FAIL wr_en_handshake cyc=%0d got=%b want=%b", cyc, s_en, |(req_valid & s_ready));
        end
        if (s_en) begin
            wid = s_data[9:8];
            checks++;
            if (wid !== s_gid || s_data[7:0] !== exp_pay[wid]) begin
                errors++;
                $display("FAIL wr_order cyc=%0d got id=%0d data=%h want id=%0d data=%h",
                         cyc, wid, s_data[7:0], s_gid, exp_pay[wid]);
            end
            exp_pay[wid] = exp_pay[wid] + 8'd1;
            wr_log.push_back(int'(wid));
            last_data = s_data;
        end else begin
            checks++;
            if (s_data !== last_data) begin
                errors++;
                $display("FAIL wr_data_hold cyc=%0d got=%h want=%h", cyc, s_data, last_data);
            end
        end
        if (cyc < 32) begin
            en_hist[cyc]   = s_en;
            busy_hist[cyc] = s_busy;
        end
        @(posedge clk);
        #1;
        if (s_en) begin
            rem[wid] = rem[wid] - 1;
            pay[wid] = pay[wid] + 8'd1;
        end
        cyc++;
        apply();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0 && !busy) done = 1'b1;
            else cycle();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout got=busy want=idle");
        end
    endtask

    task automatic check_log(input string name, input int exp_ids [$]);
        checks++;
        if (wr_log.size() != exp_ids.size()) begin
            errors++;
            $display("FAIL %s_len got=%0d want=%0d", name, wr_log.size(), exp_ids.size());
        end else begin
            for (int i = 0; i < exp_ids.size(); i++) begin
                if (wr_log[i] != exp_ids[i]) begin
                    errors++;
                    $display("FAIL %s_id[%0d] got=%0d want=%0d", name, i, wr_log[i], exp_ids[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(1, 2, 8'h10);
        set_req(3, 1, 8'h30);
        apply();
        b_req_valid = 4'hF;
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'h0 || fifo_wr_data !== 10'h0 ||
            grant_id !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b rdy=%h data=%h gid=%0d busy=%b want all zero",
                     fifo_wr_en, req_ready, fifo_wr_data, grant_id, busy);
        end
        checks++;
        if (b_wr_en !== 1'b0 || b_req_ready !== 4'h0 || b_wr_data !== 10'h0 ||
            b_grant_id !== 2'd0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_b got en=%b rdy=%h data=%h gid=%0d busy=%b want all zero",
                     b_wr_en, b_req_ready, b_wr_data, b_grant_id, b_busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_req_valid = '0;
        clear_tracking();
        cycle();
        checks++;
        if (s_busy !== 1'b0 || s_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle got busy=%b en=%b want 0 0", s_busy, s_en);
        end
        cycle();
        checks++;
        if (s_busy !== 1'b1 || s_gid !== 2'd1 || s_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got busy=%b gid=%0d en=%b want 1 1 1", s_busy, s_gid, s_en);
        end
        drain();
        check_log("reset_order", '{1, 1, 3});
    endtask

    task automatic test_single_bursts();
        do_reset();
        set_req(2, 10, 8'h20);
        apply();
        drain();
        checks++;
        if (en_hist[14:0] !== 15'h1BDE) begin
            errors++;
            $display("FAIL burst_wr_pattern got=%h want=%h", en_hist[14:0], 15'h1BDE);
        end
        checks++;
        if (busy_hist[14:0] !== 15'h3BDE) begin
            errors++;
            $display("FAIL burst_busy_pattern got=%h want=%h", busy_hist[14:0], 15'h3BDE);
        end
        check_log("burst_ids", '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2});
    endtask

    task automatic test_round_robin_b1();
        int ids [$];
        logic [9:0] hist;
        do_reset();
        b_req_valid = 4'hF;
        b_req_data  = 32'h33221100;
        hist = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            hist[c] = b_wr_en;
            if (b_wr_en) begin
                ids.push_back(int'(b_wr_data[9:8]));
                checks++;
                if (b_wr_data[7:0] !== {2'b00, b_wr_data[9:8], 2'b00, b_wr_data[9:8]}) begin
                    errors++;
                    $display("FAIL rr_payload got=%h want=%h", b_wr_data[7:0],
                             {2'b00, b_wr_data[9:8], 2'b00, b_wr_data[9:8]});
                end
            end
            @(posedge clk);
            #1;
        end
        b_req_valid = '0;
        checks++;
        if (hist !== 10'h2AA) begin
            errors++;
            $display("FAIL rr_wr_pattern got=%h want=%h", hist, 10'h2AA);
        end
        checks++;
        if (ids.size() != 5 || ids[0] != 0 || ids[1] != 1 || ids[2] != 2 || ids[3] != 3 || ids[4] != 0) begin
            errors++;
            $display("FAIL rr_order got size=%0d want 0,1,2,3,0", ids.size());
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        set_req(1, 6, 8'h40);
        apply();
        repeat (3) cycle();
        fifo_wr_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (s_ready[1] !== 1'b0 || s_busy !== 1'b1 || s_gid !== 2'd1) begin
                errors++;
                $display("FAIL full_hold c=%0d got rdy=%b busy=%b gid=%0d want 0 1 1", c, s_ready[1], s_busy, s_gid);
            end
        end
        fifo_wr_full = 1'b0;
        repeat (3) cycle();
        checks++;
        if (en_hist[10:0] !== 11'h306) begin
            errors++;
            $display("FAIL full_wr_pattern got=%h want=%h", en_hist[10:0], 11'h306);
        end
        checks++;
        if (busy_hist[10:0] !== 11'h3FE) begin
            errors++;
            $display("FAIL full_busy_pattern got=%h want=%h", busy_hist[10:0], 11'h3FE);
        end
        drain();
    endtask

    task automatic test_valid_drop();
        do_reset();
        set_req(3, 1, 8'h30);
        apply();
        repeat (2) cycle();
        set_req(0, 2, 8'h00);
        set_req(2, 2, 8'h20);
        apply();
        drain();
        check_log("drop_order", '{3, 0, 0, 2, 2});
        checks++;
        if (en_hist[10:0] !== 11'h332) begin
            errors++;
            $display("FAIL drop_wr_pattern got=%h want=%h", en_hist[10:0], 11'h332);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(0, 6, 8'h50);
        set_req(2, 3, 8'h70);
        apply();
        repeat (2) cycle();
        rst = 1'b1;
        #2;
        checks++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'h0 || fifo_wr_data !== 10'h0 ||
            grant_id !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got en=%b rdy=%h data=%h gid=%0d busy=%b want all zero",
                     fifo_wr_en, req_ready, fifo_wr_data, grant_id, busy);
        end
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_write got=%b want=0", fifo_wr_en);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_edge got en=%b busy=%b want 0 0", fifo_wr_en, busy);
        end
        rst = 1'b0;
        clear_tracking();
        drain();
        check_log("midrst_order", '{0, 0, 0, 0, 2, 2, 2, 0});
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        checks       = 0;
        errors       = 0;
        fifo_wr_full = 1'b0;
        b_wr_full    = 1'b0;
        b_req_valid  = '0;
        b_req_data   = '0;
        for (int i = 0; i < 4; i++) begin
            rem[i]     = 0;
            pay[i]     = '0;
            exp_pay[i] = '0;
        end
        apply();
        clear_tracking();
        test_reset();
        test_single_bursts();
        test_round_robin_b1();
        test_full_stall();
        test_valid_drop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
